// File: rtl/fwd_pkg.sv
// Shared types and constants for the decode-stage forwarding / hazard controller.
// Stage records carry a fixed-width destination field; narrower register files zero-extend into it.
package fwd_pkg;

    localparam int FWD_AW_MAX = 8;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [FWD_AW_MAX-1:0] dst;
        logic                  reg_wr;
        logic                  is_load;
        logic                  sp_wr;
    } stage_rec_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fsm_state_t;

    // A stage can supply a value when it is live, writes the target and, unless loads are allowed, is not a load.
    function automatic logic stage_hit(
        input stage_rec_t            rec,
        input logic [FWD_AW_MAX-1:0] addr,
        input logic                  is_sp,
        input logic                  allow_load
    );
        logic wr;
        wr = is_sp ? rec.sp_wr : rec.reg_wr;
        return rec.valid & wr & (allow_load | ~rec.is_load) & (is_sp | (rec.dst == addr));
    endfunction

endpackage

// File: rtl/fwd_operand_cmp.sv
// Priority compare of one source operand against the EX/MEM/WB shadow records.
// IS_SP=1 compares against the stack-pointer write flag and ignores addresses.
module fwd_operand_cmp
    import fwd_pkg::*;
#(
    parameter bit IS_SP = 1'b0
) (
    input  stage_rec_t            i_ex,
    input  stage_rec_t            i_mem,
    input  stage_rec_t            i_wb,
    input  logic [FWD_AW_MAX-1:0] i_src,
    input  logic                  i_used,
    output logic [1:0]            o_sel
);

    // Youngest writer wins; WB hits read the regfile because it writes before it is read.
    always_comb begin
        o_sel = FWD_RF;
        if (i_used && stage_hit(i_ex, i_src, IS_SP, IS_SP)) begin
            o_sel = FWD_EXMEM;
        end else if (stage_hit(i_mem, i_src, IS_SP, 1'b1)) begin
            o_sel = FWD_MEMWB;
        end else if (stage_hit(i_wb, i_src, IS_SP, 1'b1)) begin
            o_sel = FWD_RF;
        end else begin
            o_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode-stage forwarding and load-use hazard controller with its own EX/MEM/WB shadow records.
// Optional stall-cycle counter enabled with FWD_HAZARD_PERF_EN.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW         = 3,
    parameter int NUM_SRC        = 2,
    parameter int LOAD_STALL_CYC = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
`ifdef FWD_HAZARD_PERF_EN
    input  logic                      i_perf_clr,
    output logic [31:0]               o_perf_stall_cnt,
`endif
    input  logic                      i_id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] i_id_src_addr,
    input  logic [NUM_SRC-1:0]        i_id_src_used,
    input  logic [REG_AW-1:0]         i_id_dst_addr,
    input  logic                      i_id_reg_wr,
    input  logic                      i_id_is_load,
    input  logic                      i_id_sp_wr,
    input  logic                      i_id_sp_rd,
    input  logic                      i_pipe_hold,
    input  logic                      i_flush,
    output logic [2*NUM_SRC-1:0]      o_fwd_sel,
    output logic [1:0]                o_sp_fwd_sel,
    output logic                      o_stall_id,
    output logic                      o_bubble_ex
);

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYC - 1);

    stage_rec_t            r_ex;
    stage_rec_t            r_mem;
    stage_rec_t            r_wb;
    fsm_state_t            r_state;
    fsm_state_t            w_state_nxt;
    logic [1:0]            r_cnt;
    logic [1:0]            w_cnt_nxt;
    logic [2*NUM_SRC-1:0]  r_fwd_sel;
    logic [2*NUM_SRC-1:0]  w_fwd_sel;
    logic [1:0]            r_sp_fwd_sel;
    logic [1:0]            w_sp_fwd_sel;
    logic                  r_bubble_ex;
    logic                  w_src_hit;
    logic                  w_hazard;
    logic                  w_stall_raw;
    logic                  w_stall;
    logic                  w_flush;
    logic                  w_issue;
    stage_rec_t            w_id_rec;
    logic [FWD_AW_MAX-1:0] w_src_ext [NUM_SRC];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_op
        assign w_src_ext[k] = FWD_AW_MAX'(i_id_src_addr[k*REG_AW +: REG_AW]);

        fwd_operand_cmp #(.IS_SP(1'b0)) u_cmp (
            .i_ex   (r_ex),
            .i_mem  (r_mem),
            .i_wb   (r_wb),
            .i_src  (w_src_ext[k]),
            .i_used (i_id_src_used[k]),
            .o_sel  (w_fwd_sel[2*k +: 2])
        );
    end

    fwd_operand_cmp #(.IS_SP(1'b1)) u_sp_cmp (
        .i_ex   (r_ex),
        .i_mem  (r_mem),
        .i_wb   (r_wb),
        .i_src  ({FWD_AW_MAX{1'b0}}),
        .i_used (i_id_sp_rd),
        .o_sel  (w_sp_fwd_sel)
    );

    // Load-use hazard: a used source names the destination of a load currently in EX.
    always_comb begin
        w_src_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (i_id_src_used[k] && (w_src_ext[k] == r_ex.dst)) begin
                w_src_hit = 1'b1;
            end else begin
                w_src_hit = w_src_hit;
            end
        end
        w_hazard = i_id_valid & r_ex.valid & r_ex.is_load & r_ex.reg_wr & w_src_hit;
    end

    // Stall FSM next state; a flush (unless frozen by hold) cancels the stall in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall_raw = 1'b0;
        case (r_state)
            RUN: begin
                if (w_hazard) begin
                    w_stall_raw = 1'b1;
                    w_state_nxt = STALL;
                    w_cnt_nxt   = STALL_INIT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            STALL: begin
                if (r_cnt != 2'd0) begin
                    w_stall_raw = 1'b1;
                    w_cnt_nxt   = r_cnt - 2'd1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    assign w_flush = i_flush & ~i_pipe_hold;
    assign w_stall = w_stall_raw & ~w_flush;
    assign w_issue = i_id_valid & ~w_stall & ~w_flush;

    assign w_id_rec.valid   = 1'b1;
    assign w_id_rec.dst     = FWD_AW_MAX'(i_id_dst_addr);
    assign w_id_rec.reg_wr  = i_id_reg_wr;
    assign w_id_rec.is_load = i_id_is_load;
    assign w_id_rec.sp_wr   = i_id_sp_wr;

    // FSM state register, frozen by hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else if (!i_pipe_hold) begin
            if (w_flush) begin
                r_state <= RUN;
                r_cnt   <= 2'd0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end
    end

    // Shadow records and EX-stage selects; a non-issued slot becomes a bubble with cleared selects.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ex         <= '0;
            r_mem        <= '0;
            r_wb         <= '0;
            r_fwd_sel    <= '0;
            r_sp_fwd_sel <= FWD_RF;
            r_bubble_ex  <= 1'b0;
        end else if (!i_pipe_hold) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_issue) begin
                r_ex         <= w_id_rec;
                r_fwd_sel    <= w_fwd_sel;
                r_sp_fwd_sel <= w_sp_fwd_sel;
                r_bubble_ex  <= 1'b0;
            end else begin
                r_ex         <= '0;
                r_fwd_sel    <= '0;
                r_sp_fwd_sel <= FWD_RF;
                r_bubble_ex  <= 1'b1;
            end
        end
    end

    assign o_fwd_sel    = r_fwd_sel;
    assign o_sp_fwd_sel = r_sp_fwd_sel;
    assign o_bubble_ex  = r_bubble_ex;
    assign o_stall_id   = w_stall;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] r_perf_cnt;

    // Saturating count of non-held stall cycles; clear wins over increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_cnt <= 32'd0;
        end else if (i_perf_clr) begin
            r_perf_cnt <= 32'd0;
        end else if (!i_pipe_hold && w_stall && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign o_perf_stall_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: one instance with LOAD_STALL_CYC=1, one with 2, sharing stimulus.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_src_addr = 6'd0;
    logic [1:0] id_src_used = 2'b00;
    logic [2:0] id_dst_addr = 3'd0;
    logic       id_reg_wr = 1'b0;
    logic       id_is_load = 1'b0;
    logic       id_sp_wr = 1'b0;
    logic       id_sp_rd = 1'b0;
    logic       hold = 1'b0;
    logic       flush = 1'b0;

    logic [3:0] sel1, sel2;
    logic [1:0] sp1, sp2;
    logic       stall1, stall2, bub1, bub2;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FWD_HAZARD_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf1, perf2;
`endif

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(3), .NUM_SRC(2), .LOAD_STALL_CYC(1)) dut1 (
        .i_clk(clk), .i_rst(rst),
`ifdef FWD_HAZARD_PERF_EN
        .i_perf_clr(perf_clr), .o_perf_stall_cnt(perf1),
`endif
        .i_id_valid(id_valid), .i_id_src_addr(id_src_addr), .i_id_src_used(id_src_used),
        .i_id_dst_addr(id_dst_addr), .i_id_reg_wr(id_reg_wr), .i_id_is_load(id_is_load),
        .i_id_sp_wr(id_sp_wr), .i_id_sp_rd(id_sp_rd), .i_pipe_hold(hold), .i_flush(flush),
        .o_fwd_sel(sel1), .o_sp_fwd_sel(sp1), .o_stall_id(stall1), .o_bubble_ex(bub1)
    );

    fwd_hazard_ctrl #(.REG_AW(3), .NUM_SRC(2), .LOAD_STALL_CYC(2)) dut2 (
        .i_clk(clk), .i_rst(rst),
`ifdef FWD_HAZARD_PERF_EN
        .i_perf_clr(perf_clr), .o_perf_stall_cnt(perf2),
`endif
        .i_id_valid(id_valid), .i_id_src_addr(id_src_addr), .i_id_src_used(id_src_used),
        .i_id_dst_addr(id_dst_addr), .i_id_reg_wr(id_reg_wr), .i_id_is_load(id_is_load),
        .i_id_sp_wr(id_sp_wr), .i_id_sp_rd(id_sp_rd), .i_pipe_hold(hold), .i_flush(flush),
        .o_fwd_sel(sel2), .o_sp_fwd_sel(sp2), .o_stall_id(stall2), .o_bubble_ex(bub2)
    );

    task automatic set_instr(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                             input logic [1:0] used, input logic [2:0] dst, input logic wr,
                             input logic ld, input logic spw, input logic spr);
        id_valid    = v;
        id_src_addr = {s1, s0};
        id_src_used = used;
        id_dst_addr = dst;
        id_reg_wr   = wr;
        id_is_load  = ld;
        id_sp_wr    = spw;
        id_sp_rd    = spr;
    endtask

    task automatic nop();
        set_instr(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nop();
        hold  = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (sel1 !== 4'b0000) begin n_err++; $display("FAIL reset_sel: got %b want 0000", sel1); end
        n_cmp++; if (sp1 !== 2'b00) begin n_err++; $display("FAIL reset_sp: got %b want 00", sp1); end
        n_cmp++; if (bub1 !== 1'b0) begin n_err++; $display("FAIL reset_bubble: got %b want 0", bub1); end
        n_cmp++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall1); end
        rst = 1'b0;
    endtask

    task automatic test_exmem_fwd();
        do_reset();
        set_instr(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD r1,r2,r3
        tick();
        n_cmp++; if (bub1 !== 1'b0) begin n_err++; $display("FAIL exmem_add_bubble: got %b want 0", bub1); end
        set_instr(1'b1, 3'd1, 3'd3, 2'b11, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);   // SUB r2,r1,r3
        #1;
        n_cmp++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL exmem_stall: got %b want 0", stall1); end
        tick();
        n_cmp++; if (sel1 !== 4'b0001) begin n_err++; $display("FAIL exmem_sel: got %b want 0001", sel1); end
        // unused operand naming the EX destination must not forward
        do_reset();
        set_instr(1'b1, 3'd5, 3'd6, 2'b11, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_instr(1'b1, 3'd5, 3'd6, 2'b11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_instr(1'b1, 3'd1, 3'd1, 2'b01, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (sel1 !== 4'b0001) begin n_err++; $display("FAIL used_gate_sel: got %b want 0001", sel1); end
        // youngest writer wins when EX and MEM both write r1
        do_reset();
        set_instr(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_instr(1'b1, 3'd5, 3'd6, 2'b11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_instr(1'b1, 3'd1, 3'd1, 2'b11, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (sel1 !== 4'b0101) begin n_err++; $display("FAIL youngest_sel: got %b want 0101", sel1); end
    endtask

    task automatic test_memwb_fwd();
        do_reset();
        set_instr(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        n_cmp++; if (bub1 !== 1'b1) begin n_err++; $display("FAIL memwb_nop_bubble: got %b want 1", bub1); end
        set_instr(1'b1, 3'd1, 3'd1, 2'b11, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);   // OR r4,r1,r1
        tick();
        n_cmp++; if (sel1 !== 4'b1010) begin n_err++; $display("FAIL memwb_sel: got %b want 1010", sel1); end
        do_reset();
        set_instr(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        tick();
        set_instr(1'b1, 3'd1, 3'd1, 2'b11, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (sel1 !== 4'b0000) begin n_err++; $display("FAIL wb_sel: got %b want 0000", sel1); end
        n_cmp++; if (bub1 !== 1'b0) begin n_err++; $display("FAIL wb_bubble: got %b want 0", bub1); end
    endtask

    task automatic load_then_and();
        set_instr(1'b1, 3'd7, 3'd0, 2'b01, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);   // LDD r5
        tick();
        set_instr(1'b1, 3'd5, 3'd0, 2'b11, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);   // AND r6,r5,r0
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        load_then_and();
        n_cmp++; if (stall1 !== 1'b1) begin n_err++; $display("FAIL lu1_stall: got %b want 1", stall1); end
        tick();
        n_cmp++; if (bub1 !== 1'b1) begin n_err++; $display("FAIL lu1_bubble: got %b want 1", bub1); end
        n_cmp++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL lu1_release: got %b want 0", stall1); end
        tick();
        n_cmp++; if (sel1 !== 4'b0010) begin n_err++; $display("FAIL lu1_sel: got %b want 0010", sel1); end
        n_cmp++; if (bub1 !== 1'b0) begin n_err++; $display("FAIL lu1_issue_bubble: got %b want 0", bub1); end
    endtask

    task automatic test_load_use_2();
        do_reset();
        load_then_and();
        n_cmp++; if (stall2 !== 1'b1) begin n_err++; $display("FAIL lu2_stall_a: got %b want 1", stall2); end
        tick();
        n_cmp++; if (stall2 !== 1'b1) begin n_err++; $display("FAIL lu2_stall_b: got %b want 1", stall2); end
        n_cmp++; if (bub2 !== 1'b1) begin n_err++; $display("FAIL lu2_bubble_b: got %b want 1", bub2); end
        tick();
        n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL lu2_release: got %b want 0", stall2); end
        n_cmp++; if (bub2 !== 1'b1) begin n_err++; $display("FAIL lu2_bubble_c: got %b want 1", bub2); end
        tick();
        n_cmp++; if (bub2 !== 1'b0) begin n_err++; $display("FAIL lu2_issue_bubble: got %b want 0", bub2); end
        n_cmp++; if (sel2 !== 4'b0000) begin n_err++; $display("FAIL lu2_sel: got %b want 0000", sel2); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        load_then_and();
        flush = 1'b1;
        #1;
        n_cmp++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL flush_stall1: got %b want 0", stall1); end
        n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL flush_stall2: got %b want 0", stall2); end
        tick();
        flush = 1'b0;
        n_cmp++; if (bub1 !== 1'b1) begin n_err++; $display("FAIL flush_bubble: got %b want 1", bub1); end
        n_cmp++; if (sel1 !== 4'b0000) begin n_err++; $display("FAIL flush_sel: got %b want 0000", sel1); end
        #1;
        n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL flush_fsm_run: got %b want 0", stall2); end
        tick();
        n_cmp++; if (sel1 !== 4'b0010) begin n_err++; $display("FAIL flush_reissue_sel1: got %b want 0010", sel1); end
        n_cmp++; if (sel2 !== 4'b0010) begin n_err++; $display("FAIL flush_reissue_sel2: got %b want 0010", sel2); end
    endtask

    task automatic test_sp();
        do_reset();
        set_instr(1'b1, 3'd3, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);   // PUSH
        tick();
        set_instr(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);   // POP r3
        tick();
        n_cmp++; if (sp1 !== 2'b01) begin n_err++; $display("FAIL sp_exmem: got %b want 01", sp1); end
        nop();
        tick();
        n_cmp++; if (sp1 !== 2'b00) begin n_err++; $display("FAIL sp_nop: got %b want 00", sp1); end
        set_instr(1'b1, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (sp1 !== 2'b10) begin n_err++; $display("FAIL sp_memwb: got %b want 10", sp1); end
    endtask

    task automatic test_hold();
        do_reset();
        set_instr(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_instr(1'b1, 3'd1, 3'd3, 2'b11, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        hold = 1'b1;
        set_instr(1'b1, 3'd2, 3'd2, 2'b11, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (sel1 !== 4'b0001) begin n_err++; $display("FAIL hold_sel: got %b want 0001", sel1); end
        n_cmp++; if (bub1 !== 1'b0) begin n_err++; $display("FAIL hold_bubble: got %b want 0", bub1); end
        do_reset();
        load_then_and();
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (stall2 !== 1'b1) begin n_err++; $display("FAIL hold_stall[%0d]: got %b want 1", i, stall2); end
            n_cmp++; if (bub2 !== 1'b1) begin n_err++; $display("FAIL hold_bub[%0d]: got %b want 1", i, bub2); end
        end
        hold = 1'b0;
        #1;
        n_cmp++; if (stall2 !== 1'b1) begin n_err++; $display("FAIL hold_resume: got %b want 1", stall2); end
        tick();
        n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL hold_done: got %b want 0", stall2); end
        tick();
        n_cmp++; if (bub2 !== 1'b0) begin n_err++; $display("FAIL hold_issue: got %b want 0", bub2); end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_then_and();
        tick();
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL arst_stall: got %b want 0", stall2); end
        n_cmp++; if (bub2 !== 1'b0) begin n_err++; $display("FAIL arst_bubble2: got %b want 0", bub2); end
        n_cmp++; if (bub1 !== 1'b0) begin n_err++; $display("FAIL arst_bubble1: got %b want 0", bub1); end
        n_cmp++; if (sel2 !== 4'b0000) begin n_err++; $display("FAIL arst_sel: got %b want 0000", sel2); end
        nop();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_exmem_fwd();
        test_memwb_fwd();
        test_load_use();
        test_load_use_2();
        test_flush_stall();
        test_sp();
        test_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
